vga_timing_gen: RTL and testbench

//   Source end of the pixel interface: sweeps the raster, drives xPos/yPos to the pixel

---
 rtl/vga_timing_gen.sv | 136 +++++++++++++
 tb/tb_vga_timing_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing source: sweeps xPos/yPos and aligns sync, blank and gated RGB to returned pixels.
// Latency: outputs lag the counter position by PIX_LATENCY+1 clocks.
// Backpressure: none; free-running at one pixel per clock.
//
// Ports:
//   vga_clk, RST              pixel clock, synchronous active-high reset
//   red_in/green_in/blue_in   colour from pixel generators, PIX_LATENCY clocks after xPos/yPos
//   xPos, yPos                raster counters, driven straight from registers
//   vga_r/vga_g/vga_b         colour gated to zero outside the visible area
//   hsync, vsync, blank_n     registered sync/blank, aligned with vga_r/g/b
//   frame_start               one-clock pulse while xPos=yPos=0 (never in the first frame)
module vga_timing_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SYNC_POL    = 0,
  parameter int PIX_LATENCY = 1
) (
  input  logic       vga_clk,
  input  logic       RST,
  input  logic [9:0] red_in,
  input  logic [9:0] green_in,
  input  logic [9:0] blue_in,
  output logic [9:0] xPos,
  output logic [9:0] yPos,
  output logic [9:0] vga_r,
  output logic [9:0] vga_g,
  output logic [9:0] vga_b,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // Idle level of the sync pins; XOR with the active-high decode yields the pin level.
  localparam logic SYNC_IDLE = ~(1'(SYNC_POL));

  logic [9:0] x_q, x_d, y_q, y_d;
  logic       line_end, frame_end;
  logic       act_raw, hs_raw, vs_raw;

  logic [PIX_LATENCY-1:0] act_pipe_q, hs_pipe_q, vs_pipe_q;
  logic                   act_dly, hs_dly, vs_dly;

  logic [9:0] vga_r_q, vga_g_q, vga_b_q;
  logic       hsync_q, vsync_q, blank_n_q, frame_start_q;

  // Counter next-state
  always_comb begin
    line_end  = (x_q == H_LAST);
    frame_end = line_end && (y_q == V_LAST);
    x_d       = line_end ? 10'd0 : x_q + 10'd1;
    y_d       = y_q;
    if (line_end) begin
      y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
    end
  end

  // Raw decode of the current counter position
  always_comb begin
    act_raw = (x_q < H_VIS) && (y_q < V_VIS);
    hs_raw  = (x_q >= HS_START) && (x_q < HS_END);
    vs_raw  = (y_q >= VS_START) && (y_q < VS_END);
  end

  // Taps at the depth of the pixel generators, so decode meets its colour in the output register
  assign act_dly = act_pipe_q[PIX_LATENCY-1];
  assign hs_dly  = hs_pipe_q[PIX_LATENCY-1];
  assign vs_dly  = vs_pipe_q[PIX_LATENCY-1];

  always_ff @(posedge vga_clk) begin
    if (RST) begin
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      act_pipe_q    <= '0;
      hs_pipe_q     <= '0;
      vs_pipe_q     <= '0;
      blank_n_q     <= 1'b0;
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      vga_r_q       <= '0;
      vga_g_q       <= '0;
      vga_b_q       <= '0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      // Only a wrap sets this, so the post-reset (0,0) of frame 1 never pulses
      frame_start_q <= frame_end;

      act_pipe_q[0] <= act_raw;
      hs_pipe_q[0]  <= hs_raw;
      vs_pipe_q[0]  <= vs_raw;
      for (int i = 1; i < PIX_LATENCY; i++) begin
        act_pipe_q[i] <= act_pipe_q[i-1];
        hs_pipe_q[i]  <= hs_pipe_q[i-1];
        vs_pipe_q[i]  <= vs_pipe_q[i-1];
      end

      blank_n_q <= act_dly;
      hsync_q   <= hs_dly ^ SYNC_IDLE;
      vsync_q   <= vs_dly ^ SYNC_IDLE;
      vga_r_q   <= act_dly ? red_in   : 10'd0;
      vga_g_q   <= act_dly ? green_in : 10'd0;
      vga_b_q   <= act_dly ? blue_in  : 10'd0;
    end
  end

  assign xPos        = x_q;
  assign yPos        = y_q;
  assign frame_start = frame_start_q;
  assign blank_n     = blank_n_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vga_r       = vga_r_q;
  assign vga_g       = vga_g_q;
  assign vga_b       = vga_b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing, a reduced raster, and a tiny
// raster with two-clock pixel latency) share one clock; a cycle-count model predicts every
// output each cycle, and directed tallies pin the model against hand-computed numbers.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic [9:0] xp [3], yp [3], vr [3], vg [3], vb [3];
  logic [9:0] rin [3], gin [3], bin [3];
  logic       hs [3], vs [3], bn [3], fs [3];
  logic [9:0] xd [3][4];

  // Per-instance timing, pixel latency and red window of the bench pixel generator
  int HV [3] = '{640, 64, 8};
  int HF [3] = '{16, 4, 2};
  int HS [3] = '{96, 8, 2};
  int HB [3] = '{48, 4, 2};
  int VV [3] = '{480, 48, 4};
  int VF [3] = '{10, 2, 1};
  int VS [3] = '{2, 2, 1};
  int VB [3] = '{33, 3, 1};
  int LAT [3] = '{1, 2, 2};
  int WLO [3] = '{316, 30, 3};
  int WHI [3] = '{324, 34, 4};

  int cnt [3];
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  vga_timing_gen u0 (
    .vga_clk(clk), .RST(rst[0]), .red_in(rin[0]), .green_in(gin[0]), .blue_in(bin[0]),
    .xPos(xp[0]), .yPos(yp[0]), .vga_r(vr[0]), .vga_g(vg[0]), .vga_b(vb[0]),
    .hsync(hs[0]), .vsync(vs[0]), .blank_n(bn[0]), .frame_start(fs[0]));

  vga_timing_gen #(
    .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_VISIBLE(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SYNC_POL(0), .PIX_LATENCY(2)
  ) u1 (
    .vga_clk(clk), .RST(rst[1]), .red_in(rin[1]), .green_in(gin[1]), .blue_in(bin[1]),
    .xPos(xp[1]), .yPos(yp[1]), .vga_r(vr[1]), .vga_g(vg[1]), .vga_b(vb[1]),
    .hsync(hs[1]), .vsync(vs[1]), .blank_n(bn[1]), .frame_start(fs[1]));

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(0), .PIX_LATENCY(2)
  ) u2 (
    .vga_clk(clk), .RST(rst[2]), .red_in(rin[2]), .green_in(gin[2]), .blue_in(bin[2]),
    .xPos(xp[2]), .yPos(yp[2]), .vga_r(vr[2]), .vga_g(vg[2]), .vga_b(vb[2]),
    .hsync(hs[2]), .vsync(vs[2]), .blank_n(bn[2]), .frame_start(fs[2]));

  // Edges since the last reset edge, plus the bench pixel generators' xPos delay lines
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      cnt[i]   <= rst[i] ? 0 : cnt[i] + 1;
      xd[i][0] <= xp[i];
      for (int k = 1; k < 4; k++) xd[i][k] <= xd[i][k-1];
    end
  end

  // Pixel generators: red in a column window, green always full, blue echoes the column
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rin[i] = ((int'(xd[i][LAT[i]-1]) >= WLO[i]) && (int'(xd[i][LAT[i]-1]) <= WHI[i])) ? 10'h3FF : 10'h000;
      gin[i] = 10'h3FF;
      bin[i] = xd[i][LAT[i]-1];
    end
  end

  task automatic check(input string nm, input int inst, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[u%0d] t=%0t got=%0d expected=%0d", nm, inst, $time, got, exp);
    end
  endtask

  // Directed tallies
  bit hs_prev0 = 1'b1;
  int fall_x0 = -1;
  int hs_low_y1 = 0;
  int r_hits_y1 = 0;
  int vs_low1 = 0;
  int vfall_x1 = -1, vfall_y1 = -1;
  int fs1_a = -1, fs1_b = -1;
  int r_hits1 = 0, g_hits1 = 0, bn_hits1 = 0;
  int bn_x2 = -1, bn_y2 = -1;
  int fs2_a = -1, fs2_b = -1;
  int hs_low2 = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        int ht, vt, c, p, px, py;
        bit eact, ehs, evs, efs;
        ht = HV[i] + HF[i] + HS[i] + HB[i];
        vt = VV[i] + VF[i] + VS[i] + VB[i];
        c  = cnt[i];
        p  = c - LAT[i] - 1;
        px = 0; py = 0; eact = 0; ehs = 0; evs = 0;
        if (p >= 0) begin
          px   = p % ht;
          py   = (p / ht) % vt;
          eact = (px < HV[i]) && (py < VV[i]);
          ehs  = (px >= HV[i] + HF[i]) && (px < HV[i] + HF[i] + HS[i]);
          evs  = (py >= VV[i] + VF[i]) && (py < VV[i] + VF[i] + VS[i]);
        end
        efs = (c > 0) && (c % (ht * vt) == 0);
        check("xPos", i, 32'(xp[i]), 32'(c % ht));
        check("yPos", i, 32'(yp[i]), 32'((c / ht) % vt));
        check("blank_n", i, 32'(bn[i]), 32'(eact));
        check("hsync", i, 32'(hs[i]), 32'(!ehs));
        check("vsync", i, 32'(vs[i]), 32'(!evs));
        check("frame_start", i, 32'(fs[i]), 32'(efs));
        check("vga_r", i, 32'(vr[i]), (eact && px >= WLO[i] && px <= WHI[i]) ? 32'h3FF : 32'h0);
        check("vga_g", i, 32'(vg[i]), eact ? 32'h3FF : 32'h0);
        check("vga_b", i, 32'(vb[i]), eact ? 32'(px) : 32'h0);
      end

      if (hs_prev0 && !hs[0] && fall_x0 < 0) fall_x0 = int'(xp[0]);
      hs_prev0 = hs[0];
      if (yp[0] == 10'd1 && !hs[0]) hs_low_y1++;
      if (yp[0] == 10'd1 && vr[0] == 10'h3FF) r_hits_y1++;

      if (cnt[1] < 4400) begin
        if (!vs[1]) vs_low1++;
        if (vr[1] == 10'h3FF) r_hits1++;
        if (vg[1] == 10'h3FF) g_hits1++;
        if (bn[1]) bn_hits1++;
      end
      if (!vs[1] && vfall_x1 < 0) begin vfall_x1 = int'(xp[1]); vfall_y1 = int'(yp[1]); end
      if (fs[1]) begin
        if (fs1_a < 0) fs1_a = cnt[1];
        else if (fs1_b < 0) fs1_b = cnt[1];
      end

      if (bn[2] && bn_x2 < 0) begin bn_x2 = int'(xp[2]); bn_y2 = int'(yp[2]); end
      if (fs[2]) begin
        if (fs2_a < 0) fs2_a = cnt[2];
        else if (fs2_b < 0) fs2_b = cnt[2];
      end
      if (cnt[2] >= 3 && cnt[2] < 101 && !hs[2]) hs_low2++;
    end
  end

  initial begin
    bit hit;
    for (int i = 0; i < 3; i++) rst[i] = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    chk_en = 1'b1;

    // Reset the default instance mid-line at xPos=300, held for 3 clocks
    hit = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk);
      #2;
      if (xp[0] == 10'd300) begin hit = 1'b1; break; end
    end
    check("wait_x300", 0, 32'(hit), 32'd1);
    rst[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_xPos", 0, 32'(xp[0]), 32'd0);
    check("rst_yPos", 0, 32'(yp[0]), 32'd0);
    check("rst_vga_r", 0, 32'(vr[0]), 32'd0);
    check("rst_vga_g", 0, 32'(vg[0]), 32'd0);
    check("rst_vga_b", 0, 32'(vb[0]), 32'd0);
    check("rst_blank_n", 0, 32'(bn[0]), 32'd0);
    check("rst_hsync", 0, 32'(hs[0]), 32'd1);
    check("rst_vsync", 0, 32'(vs[0]), 32'd1);
    #2;
    rst[0] = 1'b0;
    @(negedge clk);
    check("release_xPos", 0, 32'(xp[0]), 32'd1);

    repeat (12000) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    // Default timing: sync pulse width and alignment, red window width on one line
    check("hsync_fall_x", 0, 32'(fall_x0), 32'd658);
    check("hsync_low_clks", 0, 32'(hs_low_y1), 32'd96);
    check("red_cols_line1", 0, 32'(r_hits_y1), 32'd9);
    // Reduced raster: vsync span, frame spacing, blanking tallies over frame 1
    check("vsync_low_clks", 1, 32'(vs_low1), 32'd160);
    check("vsync_fall_x", 1, 32'(vfall_x1), 32'd3);
    check("vsync_fall_y", 1, 32'(vfall_y1), 32'd50);
    check("first_frame_start", 1, 32'(fs1_a), 32'd4400);
    check("frame_start_gap", 1, 32'(fs1_b - fs1_a), 32'd4400);
    check("red_hits_frame", 1, 32'(r_hits1), 32'd240);
    check("green_hits_frame", 1, 32'(g_hits1), 32'd3072);
    check("blank_n_hits_frame", 1, 32'(bn_hits1), 32'd3072);
    // Tiny raster: 14-clk line, 98-clk frame, 3-clk output lag
    check("first_blank_x", 2, 32'(bn_x2), 32'd3);
    check("first_blank_y", 2, 32'(bn_y2), 32'd0);
    check("first_frame_start", 2, 32'(fs2_a), 32'd98);
    check("frame_start_gap", 2, 32'(fs2_b - fs2_a), 32'd98);
    check("hsync_low_frame", 2, 32'(hs_low2), 32'd14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
